// File: rtl/remote_comm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : remote_comm                                                     |
// | Purpose  : Host-side serial command bridge for the knight robot. Sends a   |
// |            16-bit command as two 8N1 UART bytes (high byte first) and      |
// |            independently receives single-byte responses.                   |
// | Options  : RC_FRAME_CHK_EN - check the received stop bit and report a bad  |
// |            frame on frame_err instead of delivering the byte.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module remote_comm #(
  parameter int BAUD_DIV = 2604  // clocks per bit, must be >= 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic        rx_rdy,
  output logic [7:0]  rx_data
`ifdef RC_FRAME_CHK_EN
  ,
  output logic        frame_err
`endif
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Command sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_SEND_HI = 2'd1,
    CMD_SEND_LO = 2'd2
  } cmd_state_t;

  cmd_state_t cmd_state_q, cmd_state_d;
  logic [7:0] lo_byte_q, lo_byte_d;
  logic       cmd_sent_q, cmd_sent_d;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done_q;

  // Next-state logic: launch the high byte, chain the low byte, flag completion
  always_comb begin
    cmd_state_d = cmd_state_q;
    lo_byte_d   = lo_byte_q;
    cmd_sent_d  = cmd_sent_q;
    tx_start    = 1'b0;
    tx_byte     = lo_byte_q;
    case (cmd_state_q)
      CMD_IDLE: begin
        if (send_cmd) begin
          lo_byte_d   = cmd[7:0];
          cmd_sent_d  = 1'b0;
          tx_start    = 1'b1;
          tx_byte     = cmd[15:8];
          cmd_state_d = CMD_SEND_HI;
        end
      end
      CMD_SEND_HI: begin
        if (tx_done_q) begin
          tx_start    = 1'b1;
          cmd_state_d = CMD_SEND_LO;
        end
      end
      CMD_SEND_LO: begin
        if (tx_done_q) begin
          cmd_sent_d  = 1'b1;
          cmd_state_d = CMD_IDLE;
        end
      end
      default: cmd_state_d = CMD_IDLE;
    endcase
  end

  // Command sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_state_q <= CMD_IDLE;
      lo_byte_q   <= 8'h00;
      cmd_sent_q  <= 1'b0;
    end else begin
      cmd_state_q <= cmd_state_d;
      lo_byte_q   <= lo_byte_d;
      cmd_sent_q  <= cmd_sent_d;
    end
  end

  assign cmd_sent = cmd_sent_q;

  // --------------------------------------------------------------------------
  // UART transmitter
  // --------------------------------------------------------------------------
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_done_d;

  // Bit timing: the line always shows shift bit 0; advance every BAUD_DIV clocks
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_busy_d  = tx_busy_q;
    tx_line_d  = tx_line_q;
    tx_done_d  = 1'b0;
    if (tx_start) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_line_d  = 1'b0;
      tx_cnt_d   = BAUD_LAST;
      tx_bit_d   = 4'd0;
      tx_busy_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        if (tx_bit_q == 4'd9) begin
          // End of stop bit; line already rests high
          tx_busy_d = 1'b0;
          tx_done_d = 1'b1;
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_line_d  = tx_shift_q[1];
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_cnt_d   = BAUD_LAST;
        end
      end else begin
        tx_cnt_d = tx_cnt_q - CNT_ONE;
      end
    end
  end

  // Transmitter registers; line forced idle-high by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_q <= 10'h3FF;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_busy_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX = tx_line_q;

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic             rx_fall;
`ifdef RC_FRAME_CHK_EN
  logic             frame_err_q, frame_err_d;
`endif

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Receive sequencing: mid-bit sampling of start, 8 data bits and stop
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = rx_rdy_q;
`ifdef RC_FRAME_CHK_EN
    frame_err_d = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_rdy_d   = 1'b0;
          rx_cnt_d   = BAUD_HALF;
          rx_bit_d   = 4'd0;
          rx_state_d = RX_RECV;
        end
      end
      RX_RECV: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d = BAUD_LAST;
          rx_bit_d = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd0) begin
            // A start bit that is high at mid-bit was only a glitch
            if (rx_sync_q) begin
              rx_state_d = RX_IDLE;
            end
          end else if (rx_bit_q == 4'd9) begin
            rx_state_d = RX_IDLE;
`ifdef RC_FRAME_CHK_EN
            if (rx_sync_q) begin
              rx_data_d = rx_shift_q;
              rx_rdy_d  = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
`else
            rx_data_d = rx_shift_q;
            rx_rdy_d  = 1'b1;
`endif
          end else begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver registers, including the two-stage synchronizer and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_rdy_q    <= 1'b0;
`ifdef RC_FRAME_CHK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= RX;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_rdy_q    <= rx_rdy_d;
`ifdef RC_FRAME_CHK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;
`ifdef RC_FRAME_CHK_EN
  assign frame_err = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_remote_comm                                                  |
// | Purpose  : Directed self-checking bench for remote_comm (command TX path,  |
// |            response RX path, loopback, reset abort, optional frame check). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_remote_comm;

  localparam int BD = 40;  // short bit time keeps the run small

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        tx_w;
  logic        rx_line;
  logic        rx_drv;
  logic        loop_en;
  logic        rx_rdy;
  logic [7:0]  rx_data;
`ifdef RC_FRAME_CHK_EN
  logic        frame_err;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  assign rx_line = loop_en ? tx_w : rx_drv;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .TX       (tx_w),
    .RX       (rx_line),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data)
`ifdef RC_FRAME_CHK_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_send(input logic [15:0] c);
    @(negedge clk);
    cmd      = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  // Find the next start bit on TX and decode the frame at mid-bit points
  task automatic get_tx_byte(output logic [7:0] b, output logic stop_b, output logic ok);
    int w;
    w      = 0;
    ok     = 1'b1;
    b      = 8'h00;
    stop_b = 1'b0;
    @(negedge clk);
    while (tx_w !== 1'b0 && w < 4 * BD) begin
      @(negedge clk);
      w++;
    end
    if (tx_w !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (BD / 2) @(negedge clk);
    if (tx_w !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = tx_w;
    end
    repeat (BD) @(negedge clk);
    stop_b = tx_w;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_drv = stop_b;
    repeat (BD) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic wait_rdy(input logic lvl, input int bound, input string tag);
    int w;
    w = 0;
    while (rx_rdy !== lvl && w < bound) begin
      @(negedge clk);
      w++;
    end
    check(tag, rx_rdy, lvl);
  endtask

  task automatic wait_sent(input int bound, input string tag);
    int w;
    w = 0;
    while (cmd_sent !== 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
    check(tag, cmd_sent, 1);
  endtask

  // Watchdog against a hung DUT handshake
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic       sb;
    logic       ok;
    int         t0;
    int         lat;
    int         lows;
    int         errs;

    rst      = 1'b1;
    cmd      = 16'h0000;
    send_cmd = 1'b0;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_tx", tx_w, 1);
    check("rst_sent", cmd_sent, 0);
    check("rst_rdy", rx_rdy, 0);
    check("rst_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Command 0x2000: bytes 0x20, 0x00 and completion latency
    pulse_send(16'h2000);
    t0 = cyc;
    check("t1_start_bit", tx_w, 0);
    check("t1_sent_low", cmd_sent, 0);
    get_tx_byte(b, sb, ok);
    check("t1_hi", {ok, sb, b}, {2'b11, 8'h20});
    get_tx_byte(b, sb, ok);
    check("t1_lo", {ok, sb, b}, {2'b11, 8'h00});
    wait_sent(2 * BD, "t1_sent");
    lat = cyc - t0;
    check("t1_latency_ok", (lat >= 20 * BD + 1 && lat <= 20 * BD + 3), 1);
    lows = 0;
    for (int i = 0; i < 3 * BD; i++) begin
      @(negedge clk);
      if (tx_w !== 1'b1) lows++;
    end
    check("t1_tx_idle", lows, 0);
    check("t1_sent_hold", cmd_sent, 1);

    // Command 0x4BF1 with a second pulse during the high byte
    pulse_send(16'h4BF1);
    check("t2_sent_clr", cmd_sent, 0);
    repeat (5) @(negedge clk);
    cmd      = 16'h0000;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    get_tx_byte(b, sb, ok);
    check("t2_hi", {ok, sb, b}, {2'b11, 8'h4B});
    get_tx_byte(b, sb, ok);
    check("t2_lo", {ok, sb, b}, {2'b11, 8'hF1});
    wait_sent(2 * BD, "t2_sent");
    lows = 0;
    for (int i = 0; i < 3 * BD; i++) begin
      @(negedge clk);
      if (tx_w !== 1'b1) lows++;
    end
    check("t2_no_third", lows, 0);

    // Receive 0xA5 then back-to-back 0x5A
    drive_rx(8'hA5, 1'b1);
    check("t3_rdy_a5", rx_rdy, 1);
    check("t3_data_a5", rx_data, 8'hA5);
    fork
      drive_rx(8'h5A, 1'b1);
      begin
        repeat (6) @(negedge clk);
        check("t3_rdy_drop", rx_rdy, 0);
      end
    join
    check("t3_rdy_5a", rx_rdy, 1);
    check("t3_data_5a", rx_data, 8'h5A);

    // Short low glitch is rejected; receiver still takes the next frame
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("t3_glitch_data", rx_data, 8'h5A);
    drive_rx(8'h3C, 1'b1);
    check("t3_rdy_3c", rx_rdy, 1);
    check("t3_data_3c", rx_data, 8'h3C);

    // Loopback of command 0x4002
    repeat (BD) @(negedge clk);
    loop_en = 1'b1;
    pulse_send(16'h4002);
    wait_rdy(1'b0, 2 * BD, "t4_drop1");
    wait_rdy(1'b1, 12 * BD, "t4_rdy1");
    check("t4_data1", rx_data, 8'h40);
    wait_rdy(1'b0, 4 * BD, "t4_drop2");
    wait_rdy(1'b1, 12 * BD, "t4_rdy2");
    check("t4_data2", rx_data, 8'h02);
    wait_sent(4 * BD, "t4_sent");
    repeat (BD) @(negedge clk);
    loop_en = 1'b0;

    // Reset in the middle of the high byte (data bit 2 of 0x4B is 0)
    pulse_send(16'h4BF1);
    repeat (3 * BD + BD / 2) @(negedge clk);
    check("t5_pre_tx", tx_w, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_tx", tx_w, 1);
    check("t5_rst_sent", cmd_sent, 0);
    check("t5_rst_rdy", rx_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse_send(16'h1234);
    get_tx_byte(b, sb, ok);
    check("t5_hi", {ok, sb, b}, {2'b11, 8'h12});
    get_tx_byte(b, sb, ok);
    check("t5_lo", {ok, sb, b}, {2'b11, 8'h34});
    wait_sent(2 * BD, "t5_sent");

`ifdef RC_FRAME_CHK_EN
    // Bad stop bit: one-cycle frame_err, byte not delivered
    errs = 0;
    fork
      drive_rx(8'h33, 1'b0);
      begin
        for (int i = 0; i < 11 * BD; i++) begin
          @(negedge clk);
          if (frame_err === 1'b1) errs++;
        end
      end
    join
    check("t6_err_pulses", errs, 1);
    check("t6_rdy", rx_rdy, 0);
    check("t6_data_kept", rx_data, 8'h00);
    repeat (BD) @(negedge clk);
    drive_rx(8'hA5, 1'b1);
    check("t6_rdy_a5", rx_rdy, 1);
    check("t6_data_a5", rx_data, 8'hA5);
    check("t6_err_idle", frame_err, 0);
`else
    errs = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
